// File: rtl/syscall_if.sv
// Core-side bundle for the SYSCALL service unit: register operands, stall/halt,
// $v0 writeback, data-memory read port and the console byte stream.
interface syscall_if;
  logic        syscall;
  logic [31:0] v0_data;
  logic [31:0] a0_data;
  logic        stall;
  logic        halted;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  modport master (
    output syscall, v0_data, a0_data, mem_rdata, out_ready,
    input  stall, halted, rf_we, rf_wdata, mem_rd, mem_addr, out_valid, out_data
  );

  modport slave (
    input  syscall, v0_data, a0_data, mem_rdata, out_ready,
    output stall, halted, rf_we, rf_wdata, mem_rd, mem_addr, out_valid, out_data
  );
endinterface

// File: rtl/syscall_unit.sv
// SYSCALL service unit: print_int, print_string, print_char, sbrk and exit for
// the single-cycle MIPS core. Holds the PC via stall until the service retires.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for syscall; captures $v0/$a0 and dispatches
// INT_SIGN  | print_int: emit '-' for negative argument, load magnitude
// INT_DIGIT | print_int: repeated subtraction of 10^k, one digit per k
// STR_REQ   | print_string: memory read of the word holding ptr in flight
// STR_WAIT  | print_string: pick the byte lane, stop on NUL or length limit
// EMIT      | present one character until out_ready
// DONE      | one unstalled cycle so the PC advances; sbrk writeback
// HALT      | exit taken; stall forever until reset
module syscall_unit #(
  parameter logic [31:0] HEAP_BASE = 32'h10000000,
  parameter logic [31:0] HEAP_SIZE = 32'h000000fc,
  parameter int          MAX_STR   = 256
) (
  input logic      clk,
  input logic      reset,
  syscall_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_STR + 1);

  typedef enum logic [2:0] {
    IDLE, INT_SIGN, INT_DIGIT, STR_REQ, STR_WAIT, EMIT, DONE, HALT
  } state_t;

  state_t      state;
  logic [31:0] code_q;
  logic [31:0] arg_q;
  logic [31:0] ptr_q;
  logic [31:0] rem_q;
  logic [3:0]  k_q;
  logic [3:0]  digit_q;
  logic        lead_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] brk_q;
  logic        halted_q;
  logic        rf_we_q;
  logic [31:0] rf_wdata_q;
  logic        mem_rd_q;
  logic [31:0] mem_addr_q;
  logic        out_valid_q;
  logic [7:0]  out_data_q;

  function automatic logic [31:0] pow10(input logic [3:0] k);
    case (k)
      4'd0:    pow10 = 32'd1;
      4'd1:    pow10 = 32'd10;
      4'd2:    pow10 = 32'd100;
      4'd3:    pow10 = 32'd1000;
      4'd4:    pow10 = 32'd10000;
      4'd5:    pow10 = 32'd100000;
      4'd6:    pow10 = 32'd1000000;
      4'd7:    pow10 = 32'd10000000;
      4'd8:    pow10 = 32'd100000000;
      default: pow10 = 32'd1000000000;
    endcase
  endfunction

  logic [31:0] sbrk_n;
  logic [32:0] sbrk_end;
  logic [32:0] heap_lim;
  logic [31:0] pow_k;
  logic [7:0]  str_byte;
  logic [31:0] ptr_next;

  assign sbrk_n   = (bus.a0_data + 32'd3) & ~32'd3;
  assign sbrk_end = {1'b0, brk_q} + {1'b0, sbrk_n};
  assign heap_lim = {1'b0, HEAP_BASE} + {1'b0, HEAP_SIZE};
  assign pow_k    = pow10(k_q);
  assign str_byte = bus.mem_rdata[{ptr_q[1:0], 3'b000} +: 8];
  assign ptr_next = ptr_q + 32'd1;

  // The only combinational output: stall must follow syscall in the same cycle.
  assign bus.stall     = (bus.syscall && state != DONE) || state == HALT;
  assign bus.halted    = halted_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Service sequencer with registered outputs; brk lives here so reset restores it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      code_q      <= '0;
      arg_q       <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      k_q         <= '0;
      digit_q     <= '0;
      lead_q      <= 1'b0;
      cnt_q       <= '0;
      brk_q       <= HEAP_BASE;
      halted_q    <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_wdata_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rf_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.syscall) begin
            code_q <= bus.v0_data;
            arg_q  <= bus.a0_data;
            case (bus.v0_data)
              32'd1: state <= INT_SIGN;
              32'd4: begin
                ptr_q      <= bus.a0_data;
                cnt_q      <= '0;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= {bus.a0_data[31:2], 2'b00};
                state      <= STR_REQ;
              end
              32'd9: begin
                rf_we_q <= 1'b1;
                if (sbrk_end <= heap_lim) begin
                  rf_wdata_q <= brk_q;
                  brk_q      <= sbrk_end[31:0];
                end else begin
                  rf_wdata_q <= 32'hFFFFFFFF;
                end
                state <= DONE;
              end
              32'd10: begin
                halted_q <= 1'b1;
                state    <= HALT;
              end
              32'd11: begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.a0_data[7:0];
                state       <= EMIT;
              end
              default: state <= DONE;
            endcase
          end
        end
        INT_SIGN: begin
          k_q     <= 4'd9;
          digit_q <= '0;
          lead_q  <= 1'b1;
          if (arg_q[31]) begin
            rem_q       <= ~arg_q + 32'd1;
            out_valid_q <= 1'b1;
            out_data_q  <= 8'h2D;
            state       <= EMIT;
          end else begin
            rem_q <= arg_q;
            state <= INT_DIGIT;
          end
        end
        INT_DIGIT: begin
          if (rem_q >= pow_k) begin
            rem_q   <= rem_q - pow_k;
            digit_q <= digit_q + 4'd1;
          end else if (digit_q != 4'd0 || !lead_q || k_q == 4'd0) begin
            out_valid_q <= 1'b1;
            out_data_q  <= 8'h30 + {4'b0000, digit_q};
            lead_q      <= 1'b0;
            state       <= EMIT;
          end else begin
            k_q <= k_q - 4'd1;
          end
        end
        STR_REQ: begin
          mem_rd_q <= 1'b0;
          state    <= STR_WAIT;
        end
        STR_WAIT: begin
          if (str_byte == 8'h00 || cnt_q == CNT_W'(MAX_STR)) begin
            state <= DONE;
          end else begin
            out_valid_q <= 1'b1;
            out_data_q  <= str_byte;
            cnt_q       <= cnt_q + CNT_W'(1);
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            case (code_q)
              32'd1: begin
                // lead still set means the '-' just went out; digits follow
                if (lead_q) begin
                  state <= INT_DIGIT;
                end else if (k_q == 4'd0) begin
                  state <= DONE;
                end else begin
                  k_q     <= k_q - 4'd1;
                  digit_q <= '0;
                  state   <= INT_DIGIT;
                end
              end
              32'd4: begin
                ptr_q      <= ptr_next;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= {ptr_next[31:2], 2'b00};
                state      <= STR_REQ;
              end
              default: state <= DONE;
            endcase
          end
        end
        DONE:    state <= IDLE;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: console services, string reads across a word
// boundary with backpressure, sbrk bookkeeping, exit and asynchronous reset.
module tb_syscall_unit;

  logic clk;
  logic reset;

  syscall_if bus();

  syscall_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // results of the last run_svc
  logic [127:0] acc;
  int ntx, done_cyc, we_cnt, rd_cnt, first_valid, hold_bad, post_we;
  logic [31:0] we_data;
  logic pat [4];
  int pat_len;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h10000000: mem_word = 32'h21694800;  // bytes: xx 'H' 'i' '!'
      32'h10000004: mem_word = 32'h5A5A5A00;  // NUL first
      default:      mem_word = 32'hA5A5A5A5;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem_word(bus.mem_addr);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one syscall starting in the current cycle (cycle 0) and follow it to DONE.
  task automatic run_svc(input logic [31:0] v0, input logic [31:0] a0, input int budget);
    int idx;
    logic prev_hold;
    logic [7:0] prev_data;
    acc = '0; ntx = 0; done_cyc = -1; we_cnt = 0; rd_cnt = 0;
    first_valid = -1; hold_bad = 0; idx = 0; prev_hold = 1'b0; prev_data = '0;
    we_data = '0;
    bus.syscall = 1'b1; bus.v0_data = v0; bus.a0_data = a0; bus.out_ready = 1'b0;
    #1;
    chk("stall_c0", 128'(bus.stall), 128'(1));
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      if (prev_hold && (!bus.out_valid || bus.out_data !== prev_data)) hold_bad++;
      prev_hold = 1'b0;
      if (bus.mem_rd) rd_cnt++;
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = c;
        bus.out_ready = pat[idx % pat_len];
        idx++;
        if (bus.out_ready) begin
          acc = {acc[119:0], bus.out_data};
          ntx++;
        end else begin
          prev_hold = 1'b1;
          prev_data = bus.out_data;
        end
      end
      if (bus.rf_we) begin
        we_cnt++;
        we_data = bus.rf_wdata;
      end
      if (!bus.stall) begin
        done_cyc = c;
        break;
      end
    end
    bus.syscall = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    post_we = int'(bus.rf_we);
  endtask

  initial begin
    int got, hit, bad;
    n_checks = 0; n_fail = 0;
    clk = 1'b0; reset = 1'b0;
    bus.syscall = 1'b0; bus.v0_data = '0; bus.a0_data = '0; bus.out_ready = 1'b0;
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b1; pat_len = 1;

    #2;
    chk("rst_stall",     128'(bus.stall),     128'(0));
    chk("rst_halted",    128'(bus.halted),    128'(0));
    chk("rst_rf_we",     128'(bus.rf_we),     128'(0));
    chk("rst_rf_wdata",  128'(bus.rf_wdata),  128'(0));
    chk("rst_mem_rd",    128'(bus.mem_rd),    128'(0));
    chk("rst_mem_addr",  128'(bus.mem_addr),  128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data",  128'(bus.out_data),  128'(0));
    bus.syscall = 1'b1;
    #1;
    chk("rst_stall_follows", 128'(bus.stall), 128'(1));
    bus.syscall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // unknown code is a no-op
    run_svc(32'd0, 32'd0, 20);
    chk("noop_done", 128'(done_cyc), 128'(1));
    chk("noop_tx",   128'(ntx),      128'(0));
    chk("noop_we",   128'(we_cnt),   128'(0));

    // print_char
    run_svc(32'd11, 32'h41, 20);
    chk("char_done",  128'(done_cyc),    128'(2));
    chk("char_first", 128'(first_valid), 128'(1));
    chk("char_tx",    128'(ntx),         128'(1));
    chk("char_data",  acc,               128'(8'h41));

    // print_int
    run_svc(32'd1, -32'sd305, 300);
    chk("int_neg",      acc,                 128'("-305"));
    chk("int_neg_tx",   128'(ntx),           128'(4));
    chk("int_neg_done", 128'(done_cyc > 0),  128'(1));
    run_svc(32'd1, 32'd0, 300);
    chk("int_zero",     acc,                 128'("0"));
    chk("int_zero_tx",  128'(ntx),           128'(1));
    run_svc(32'd1, 32'd1000, 300);
    chk("int_1000",     acc,                 128'("1000"));
    run_svc(32'd1, 32'h80000000, 400);
    chk("int_min",      acc,                 128'("-2147483648"));
    chk("int_min_done", 128'(done_cyc > 0),  128'(1));

    // print_string with backpressure 1,0,0,1
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat_len = 4;
    run_svc(32'd4, 32'h10000001, 100);
    chk("str_data", acc,                128'("Hi!"));
    chk("str_tx",   128'(ntx),          128'(3));
    chk("str_hold", 128'(hold_bad),     128'(0));
    chk("str_rd",   128'(rd_cnt),       128'(4));
    chk("str_done", 128'(done_cyc),     128'(14));
    pat[0] = 1'b1; pat_len = 1;

    // sbrk
    run_svc(32'd9, 32'd5, 20);
    chk("sbrk5_v0",   128'(we_data),  128'(32'h10000000));
    chk("sbrk5_we",   128'(we_cnt),   128'(1));
    chk("sbrk5_done", 128'(done_cyc), 128'(1));
    chk("sbrk5_post", 128'(post_we),  128'(0));
    run_svc(32'd9, 32'd4, 20);
    chk("sbrk4_v0",   128'(we_data),  128'(32'h10000008));
    chk("sbrk4_we",   128'(we_cnt),   128'(1));
    run_svc(32'd9, 32'h100, 20);
    chk("sbrk_big_v0", 128'(we_data), 128'(32'hFFFFFFFF));
    chk("sbrk_big_we", 128'(we_cnt),  128'(1));
    run_svc(32'd9, 32'd0, 20);
    chk("sbrk0_brk",  128'(we_data),  128'(32'h1000000C));

    // reset in the middle of print_string, while the third char is on offer
    got = 0; hit = 0;
    bus.syscall = 1'b1; bus.v0_data = 32'd4; bus.a0_data = 32'h10000001;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      if (bus.out_valid) begin
        if (got < 2) begin
          bus.out_ready = 1'b1;
          got++;
        end else begin
          reset = 1'b0;
          hit = 1;
          break;
        end
      end
    end
    chk("rst_mid_hit", 128'(hit), 128'(1));
    #1;
    chk("rst_mid_out_valid", 128'(bus.out_valid), 128'(0));
    bus.syscall = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    run_svc(32'd9, 32'd0, 20);
    chk("rst_mid_brk", 128'(we_data), 128'(32'h10000000));

    // exit
    bus.syscall = 1'b1; bus.v0_data = 32'd10; bus.a0_data = '0;
    @(posedge clk); #1;
    chk("exit_halted", 128'(bus.halted), 128'(1));
    bus.syscall = 1'b0;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (!bus.halted || !bus.stall) bad++;
    end
    chk("exit_hold", 128'(bad), 128'(0));
    reset = 1'b0;
    #1;
    chk("exit_rst_halted", 128'(bus.halted), 128'(0));
    chk("exit_rst_stall",  128'(bus.stall),  128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/syscall_unit.md
# syscall_unit

Multi-cycle service unit that executes the SYSCALL instruction for the single-cycle MIPS core. It consumes the `$v0`/`$a0` values the datapath reads during a syscall, stalls the PC until the service finishes, and streams console characters over a valid/ready byte port. It reads string bytes from data memory, owns the heap break pointer (writing the sbrk result back into `$v0`), and latches the exit condition.

## Interface
- HEAP_BASE, 32'h10000000, first heap byte; reset value of the break pointer
- HEAP_SIZE, 32'h000000fc, heap bytes available to sbrk
- MAX_STR, 256, print_string byte limit; the string is forcibly terminated after this many bytes

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately
- syscall  in  1  decoder flag, held high while the SYSCALL instruction sits at the PC
- v0_data  in  32  service code (`$v0`)
- a0_data  in  32  argument (`$a0`)
- stall  out  1  hold PC and suppress core register and memory writes
- halted  out  1  sticky exit flag
- rf_we  out  1  write `$v0` (sbrk result)
- rf_wdata  out  32  value for `$v0`
- mem_rd  out  1  data-memory read request
- mem_addr  out  32  word-aligned read address {addr[31:2],2'b00}
- mem_rdata  in  32  read word, valid the cycle after mem_rd
- out_valid  out  1  character available
- out_data  out  8  ASCII character
- out_ready  in  1  console accepts the character

## Operation
- States: IDLE, INT_SIGN, INT_DIGIT, STR_REQ, STR_WAIT, EMIT, DONE, HALT.
- stall = syscall && state!=DONE, or state==HALT.
- IDLE with syscall=1: capture v0_data and a0_data, then dispatch:
  - 1, print_int: go to INT_SIGN.
  - 4, print_string: go to STR_REQ with ptr=a0.
  - 9, sbrk: go to DONE.
  - 10, exit: go to HALT.
  - 11, print_char: load out_data=a0[7:0] and go to EMIT.
  - Any other code: go to DONE as a no-op.
- print_int:
  - If a0 is negative, emit '-' and set mag=-a0 as unsigned 32-bit. 0x80000000 gives 2147483648.
  - INT_DIGIT walks k=9..0 and subtracts 10^k from rem once per cycle while rem≥10^k, counting the digit.
  - Emit '0'+digit unless it is a leading zero with k≠0. a0=0 prints "0".
  - After k=0, go to DONE.
- print_string:
  - STR_REQ asserts mem_rd for ptr.
  - STR_WAIT selects the byte: little-endian, byte = mem_rdata[8*ptr[1:0]+:8].
  - A NUL byte, or reaching MAX_STR bytes, goes to DONE. Otherwise EMIT, then ptr+1 and back to STR_REQ.
  - Every byte, including bytes within the same word, is re-read.
- EMIT: out_valid=1 and out_data is held stable until out_valid&&out_ready. The next state depends on the service.
- sbrk:
  - n = (a0+3)&~3.
  - If brk+n ≤ HEAP_BASE+HEAP_SIZE (33-bit compare), rf_wdata=brk and brk+=n.
  - Otherwise rf_wdata=32'hFFFFFFFF and brk is unchanged.
  - rf_we=1 only in the DONE cycle.
  - n=0 returns the current brk.
- DONE: stall=0 for exactly one cycle so the PC advances, then IDLE. IDLE ignores syscall for that following cycle only if it is still the same instruction; the decoder drops syscall once the PC moves.
- HALT: halted=1 and stall=1 forever until reset.

## Timing
- Reset values: stall=syscall (combinational), halted=0, rf_we=0, rf_wdata=0, mem_rd=0, mem_addr=0, out_valid=0, out_data=0, brk=HEAP_BASE, state IDLE.
- Cycle numbering: syscall rises at cycle 0, with stall=1.
- No-op and sbrk: DONE at cycle 1. The PC advances at the end of cycle 1, giving 2-cycle occupancy.
- print_char with out_ready=1: out_valid at cycle 1, DONE at cycle 2.
- print_string: 3 cycles per character (REQ, WAIT, EMIT) plus backpressure, then one more REQ/WAIT pair for the NUL.
- Backpressure: out_valid and out_data stay unchanged while out_ready=0. There is no timeout.
- Reset mid-service: the unit returns to IDLE at once. out_valid drops, the partial output is lost, and brk is restored to HEAP_BASE.
- syscall deasserted mid-service (core reset only): the unit finishes the service anyway.

## Test plan
- print_char: v0=11, a0=0x41, out_ready=1 -> exactly one transfer 0x41 at cycle 1; stall low only at cycle 2.
- print_int: a0=-305 -> bytes '-','3','0','5'. a0=0 -> '0'. a0=0x80000000 -> "-2147483648".
- print_string: memory holds "Hi!\0" at 0x10000001, crossing a word boundary; out_ready toggles 1,0,0,1 -> 'H','i','!' each held stable while not ready; no NUL emitted; stall deasserts once.
- sbrk: a0=5 -> v0=0x10000000; a0=4 -> v0=0x10000008; a0=0x100 -> v0=0xFFFFFFFF with brk unchanged; rf_we is a single-cycle pulse each time.
- exit: v0=10 -> halted=1 and stall=1 held for 20+ cycles; reset=0 clears both.
- Reset mid-print_string after the 2nd char -> out_valid=0 immediately; after release, a fresh v0=9, a0=0 returns 0x10000000.
